// File: rtl/uart_config_if.sv
// Configuration link bundle: serial input towards the receiver and the
// latched configuration word and status flags back to the fabric.
interface uart_config_if;
   logic        uart_rx;
   logic [51:0] config_bits;
   logic        config_done;
   logic        config_error;

   modport master (
      output uart_rx,
      input  config_bits,
      input  config_done,
      input  config_error
   );

   modport slave (
      input  uart_rx,
      output config_bits,
      output config_done,
      output config_error
   );
endinterface

// File: rtl/uart_config.sv
// Receives a 52-bit configuration word as seven 8N1 UART bytes (MSB byte first)
// and latches it atomically; framing or header faults lock into a sticky error.
module uart_config #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input logic          clk,
   input logic          rst,
   uart_config_if.slave cfg
);
   localparam int unsigned BaudDiv = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HalfDiv = BaudDiv / 2;
   localparam int unsigned CntW    = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StDone,
      StError
   } state_e;

   state_e            state_q, state_d;
   logic              rx_meta, rx_sync;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        byte_cnt_q, byte_cnt_d;
   // Holds header nibble plus up to five full bytes; the seventh byte goes
   // straight from the shift register into config_bits.
   logic [43:0]       acc_q, acc_d;
   logic [51:0]       bits_q, bits_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         acc_q      <= '0;
         bits_q     <= '0;
      end else begin
         rx_meta    <= cfg.uart_rx;
         rx_sync    <= rx_meta;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         acc_q      <= acc_d;
         bits_q     <= bits_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      acc_d      = acc_q;
      bits_d     = bits_q;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_sync) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == CntW'(HalfDiv - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync ? StError : StData;
            end
         end
         StData: begin
            if (cnt_q == CntW'(BaudDiv - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == CntW'(BaudDiv - 1)) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d = StError;
               end else if (byte_cnt_q == 3'd0 && shift_q[7:4] != 4'h0) begin
                  state_d = StError;
               end else begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  if (byte_cnt_q == 3'd0) begin
                     acc_d = {40'b0, shift_q[3:0]};
                  end else begin
                     acc_d = {acc_q[35:0], shift_q};
                  end
                  if (byte_cnt_q == 3'd6) begin
                     bits_d  = {acc_q, shift_q};
                     state_d = StDone;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         StDone, StError: cnt_d = '0;
         default: state_d = StIdle;
      endcase
   end

   assign cfg.config_bits  = bits_q;
   assign cfg.config_done  = (state_q == StDone);
   assign cfg.config_error = (state_q == StError);
endmodule

// File: tb/tb_uart_config.sv
// Drives 8N1 frames into uart_config and compares the outputs against a
// frame-level model of the configuration protocol.
module tb_uart_config;
   localparam int BitClks = 16;

   logic clk;
   logic rst;
   uart_config_if cfg ();

   uart_config #(
      .CLK_FREQ (160),
      .BAUD_RATE(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg(cfg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   // Frame-level reference model
   logic [63:0] m_acc;
   logic [51:0] m_bits;
   bit          m_done;
   bit          m_err;
   int          m_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".bits"}, 64'(cfg.config_bits), 64'(m_bits));
      check({tag, ".done"}, 64'(cfg.config_done), 64'(m_done));
      check({tag, ".err"}, 64'(cfg.config_error), 64'(m_err));
   endtask

   task automatic model_clear();
      m_acc  = '0;
      m_bits = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (m_done || m_err) return;
      if (!stop_ok || (m_cnt == 0 && b[7:4] != 4'h0)) begin
         m_err = 1'b1;
         return;
      end
      m_acc = (m_acc << 8) | 64'(b);
      m_cnt++;
      if (m_cnt == 7) begin
         m_done = 1'b1;
         m_bits = m_acc[51:0];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      cfg.uart_rx = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      model_clear();
      check_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic bit_period(input logic v);
      cfg.uart_rx = v;
      repeat (BitClks) @(negedge clk);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] b, input bit stop_ok,
                             input int gap);
      bit_period(1'b0);
      for (int i = 0; i < 8; i++) bit_period(b[i]);
      bit_period(stop_ok);
      model_frame(b, stop_ok);
      check_outputs(tag);
      repeat (gap) bit_period(1'b1);
   endtask

   task automatic send_word(input string tag, input logic [55:0] w, input int gap);
      for (int i = 6; i >= 0; i--) send_frame(tag, w[8*i +: 8], 1'b1, gap);
   endtask

   initial begin
      logic [55:0] w;
      logic [7:0]  b;
      int          fault_pos;
      int          fault_kind;
      n_vec = 0;
      n_bad = 0;
      cfg.uart_rx = 1'b1;
      rst = 1'b0;
      model_clear();
      do_reset();

      send_word("w0123", 56'h01_2345_6789_ABCD, 1);
      check("w0123.exact", 64'(cfg.config_bits), 64'h1_2345_6789_ABCD);
      do_reset();
      send_word("wzero", 56'h0, 1);
      do_reset();
      send_word("wones", 56'h0F_FFFF_FFFF_FFFF, 1);
      do_reset();
      send_word("w0aaa", 56'h0A_AAAA_AAAA_AAAA, 1);
      do_reset();
      send_word("w0001", 56'h00_0000_0000_0001, 1);
      do_reset();

      // One byte at a time with long pauses
      send_word("slow", 56'h00_AABB_CCDD_EEFF, 3);
      check("slow.exact", 64'(cfg.config_bits), 64'h0_AABB_CCDD_EEFF);
      do_reset();

      send_frame("badstop", 8'h00, 1'b1, 1);
      send_frame("badstop", 8'hAA, 1'b0, 1);
      for (int i = 0; i < 5; i++) send_frame("afterr", 8'h11, 1'b1, 1);
      do_reset();

      cfg.uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      cfg.uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      m_err = 1'b1;
      check_outputs("glitch");
      do_reset();

      send_frame("hdrF0", 8'hF0, 1'b1, 1);
      do_reset();
      send_frame("hdr05", 8'h05, 1'b1, 1);
      do_reset();

      send_word("full", 56'h07_1234_5678_9ABC, 1);
      for (int i = 0; i < 3; i++) send_frame("extra", 8'hFF, 1'b1, 0);
      repeat (100) @(negedge clk);
      check_outputs("hold");
      do_reset();

      for (int i = 0; i < 3; i++) send_frame("part", 8'h0C, 1'b1, 1);
      do_reset();
      send_word("fresh", 56'h0C_0DE0_1234_5678, 1);
      do_reset();

      send_word("b2b", 56'h03_1415_9265_3589, 0);
      check("b2b.exact", 64'(cfg.config_bits), 64'h3_1415_9265_3589);
      do_reset();

      for (int n = 0; n < 10; n++) begin
         w = {$urandom, $urandom};
         w[55:52] = 4'h0;
         fault_kind = (($urandom & 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         fault_pos = int'($urandom_range(0, 6));
         if (fault_kind == 2) w[55:52] = 4'(1 + $urandom_range(0, 14));
         for (int i = 6; i >= 0; i--) begin
            b = w[8*i +: 8];
            send_frame("rand", b, !(fault_kind == 1 && fault_pos == 6 - i),
                       int'($urandom_range(0, 2)));
         end
         do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
